// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ==== mem_port_arbiter_if : requester (I/D) and memory-side signals of mem_port_arbiter | rev 1.0 ====
// slave = arbiter side, master = requesters/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  i_req_valid;
  logic                  i_req_ready;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic                  i_rsp_valid;
  logic [DATA_WIDTH-1:0] i_rsp_data;
  logic                  d_req_valid;
  logic                  d_req_ready;
  logic [ADDR_WIDTH-1:0] d_req_addr;
  logic                  d_req_we;
  logic [DATA_WIDTH-1:0] d_req_wdata;
  logic                  d_rsp_valid;
  logic [DATA_WIDTH-1:0] d_rsp_data;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;

  modport slave (
    input  i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_we, d_req_wdata, mem_rdata,
    output i_req_ready, i_rsp_valid, i_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_we, d_req_wdata, mem_rdata,
    input  i_req_ready, i_rsp_valid, i_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ==== mem_port_arbiter : I-fetch / load-store sharing of one single-port sync memory | rev 1.0 ====
// Round-robin on ties; define MEM_PORT_ARBITER_DPRIO_EN for fixed D priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_latency
      $error("mem_port_arbiter: RD_LATENCY must be in 1..8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_last_d;
  logic                  r_owner_d;
  logic                  r_we;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_i_data;
  logic [DATA_WIDTH-1:0] r_d_data;
  logic                  r_i_rsp;
  logic                  r_d_rsp;
  logic                  w_idle;
  logic                  w_grant_i;
  logic                  w_grant_d;
  logic                  w_accept;

  // Ready is gated by reset so nothing is offered while reset is held.
  assign w_idle = (r_state == S_IDLE) && reset;

`ifdef MEM_PORT_ARBITER_DPRIO_EN
  assign w_grant_d = bus.d_req_valid;
`else
  assign w_grant_d = bus.d_req_valid && (!bus.i_req_valid || !r_last_d);
`endif
  assign w_grant_i = bus.i_req_valid && !w_grant_d;
  assign w_accept  = w_idle && (w_grant_i || w_grant_d);

  assign bus.i_req_ready = w_idle && w_grant_i;
  assign bus.d_req_ready = w_idle && w_grant_d;
  assign bus.i_rsp_valid = r_i_rsp;
  assign bus.i_rsp_data  = r_i_data;
  assign bus.d_rsp_valid = r_d_rsp;
  assign bus.d_rsp_data  = r_d_data;
  assign bus.mem_en      = r_mem_en;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: w_next = r_we ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_last_d    <= 1'b1;
      r_owner_d   <= 1'b0;
      r_we        <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_data    <= '0;
      r_d_data    <= '0;
      r_i_rsp     <= 1'b0;
      r_d_rsp     <= 1'b0;
    end else begin
      // Strobes are registered from the accept so they are high exactly during ISSUE.
      r_mem_en <= w_accept;
      r_mem_we <= w_accept && w_grant_d && bus.d_req_we;
      r_i_rsp  <= (w_next == S_RESP) && !r_owner_d;
      r_d_rsp  <= (w_next == S_RESP) && r_owner_d;

      if (w_accept) begin
        r_owner_d  <= w_grant_d;
        r_last_d   <= w_grant_d;
        r_we       <= w_grant_d && bus.d_req_we;
        r_mem_addr <= w_grant_d ? bus.d_req_addr : bus.i_req_addr;
        // Fetches carry no write data, so mem_wdata keeps the last store's value.
        if (w_grant_d) r_mem_wdata <= bus.d_req_wdata;
      end

      if (r_state == S_ISSUE) begin
        r_cnt <= CNT_W'(RD_LATENCY - 1);
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (r_state == S_WAIT && r_cnt == '0) begin
        if (r_owner_d) r_d_data <= bus.mem_rdata;
        else           r_i_data <= bus.mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction-fetch requester (I) and the load/store requester (D). Sits between `mother_board` and `memory`.
- Valid/ready request handshake per requester, one-cycle response pulse per requester.
- Round-robin arbitration on ties; memory outputs registered; configurable memory read latency.

Parameters:
- ADDR_WIDTH, 6, word address width of the shared memory
- DATA_WIDTH, 32, data word width
- RD_LATENCY, 1, cycles from the `mem_en` cycle until `mem_rdata` is valid; legal range 1..8

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- i_req_valid  input  1  fetch request present
- i_req_ready  output  1  fetch request accepted this cycle when valid is also high
- i_req_addr  input  ADDR_WIDTH  fetch word address
- i_rsp_valid  output  1  one-cycle pulse: `i_rsp_data` is valid
- i_rsp_data  output  DATA_WIDTH  fetched word
- d_req_valid  input  1  data request present
- d_req_ready  output  1  data request accepted this cycle when valid is also high
- d_req_addr  input  ADDR_WIDTH  data word address
- d_req_we  input  1  1 = store, 0 = load
- d_req_wdata  input  DATA_WIDTH  store data
- d_rsp_valid  output  1  one-cycle pulse: load data valid or store acknowledged
- d_rsp_data  output  DATA_WIDTH  load result; don't-care for a store ack
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data
- busy  output  1  high whenever state is not IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset (reset=0, asynchronous):
  - state = IDLE.
  - All outputs = 0, including both `rsp_data` registers.
  - Latency counter = 0; `last_grant` = D.
- Readiness:
  - `x_req_ready` is combinational.
  - It is 1 only in IDLE, and only for the requester the arbiter selects.
  - In IDLE: exactly one of i/d ready is high when any valid is high; both are 0 when no valid is high.
- Arbitration in IDLE:
  - Only one valid high: grant it.
  - Both valid high: grant the requester that is not `last_grant`.
  - `last_grant` updates on accept.
- Accept (cycle T, valid & ready):
  - Latch addr, we (I path: we = 0) and wdata into the registered `mem_*` outputs.
  - Record the owner; next state = ISSUE.
- ISSUE (T+1):
  - `mem_en` = 1; `mem_we` = latched we.
  - Store: next state = RESP.
  - Load: counter = RD_LATENCY-1, next state = WAIT.
- `mem_en` and `mem_we` are 1 only in ISSUE. `mem_addr` and `mem_wdata` hold their last value otherwise.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, capture `mem_rdata` into the owner's `rsp_data` register and go to RESP.
  - Capture cycle = T+1+RD_LATENCY.
- RESP:
  - Owner's `rsp_valid` = 1 for exactly one cycle; next state = IDLE.
  - Load response at T+2+RD_LATENCY; store ack at T+2.
  - Earliest next accept: T+3 (store) or T+3+RD_LATENCY (load).
- `rsp_data` holds its value until that owner's next load capture. The non-owner's response outputs never change.
- No response backpressure: requesters must consume the pulse.
- Requester rules: addr, we and wdata are stable while valid && !ready. Valid may drop without being accepted (no penalty).
- A requester may present its next request during RESP; it is accepted in IDLE the following cycle.
- Reset asserted mid-transaction (ISSUE/WAIT/RESP):
  - Transaction dropped; no `rsp_valid` is ever emitted for it.
  - Memory write not performed if reset is asserted before the ISSUE clock edge.
- Counter width = $clog2(RD_LATENCY+1). RD_LATENCY outside 1..8 is an elaboration error (`$error`).

Optional Feature:
- Macro: MEM_PORT_ARBITER_DPRIO_EN.
- Defined: fixed priority. When both valid are high in IDLE, D always wins. `last_grant` is still maintained but is unused.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset behaviour: hold reset=0 with both valids=1 → all outputs 0, busy=0. After release, IDLE with i_req_ready=1, d_req_ready=0 (tie goes to I because last_grant=D).
- Fetch, RD_LATENCY=1: i_req_addr=0x05 accepted at T → cycle T+1 mem_en=1, mem_we=0, mem_addr=0x05. Memory returns 0xDEADBEEF at T+2 → cycle T+3 i_rsp_valid=1, i_rsp_data=0xDEADBEEF; d_rsp_valid stays 0.
- Store: d_req_addr=0x10, we=1, wdata=0x12345678 accepted at T → T+1 mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0x12345678. T+2 d_rsp_valid=1; i_rsp_data unchanged.
- Contention: both valid held high for 4 transactions (addrs I=0x01, D=0x02) → grant order I, D, I, D. busy stays high except the single IDLE cycle between transactions.
- Reset mid-WAIT, RD_LATENCY=3: assert reset one cycle after ISSUE → no rsp_valid ever. After release, a new fetch to 0x07 completes 5 cycles after accept.
- MEM_PORT_ARBITER_DPRIO_EN defined: both valid high for 3 transactions → D, D, D. I is granted only once d_req_valid drops.
